mmio_axilite_arbiter: RTL and testbench



---
 rtl/mmio_axilite_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mmio_axilite_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mmio_axilite_arbiter.sv
// mmio_axilite_arbiter: round-robin sharing of one lcl_mmio channel between
// N_REQ single-beat requesters. One transaction in flight at a time.
//
// Optional feature macro: MMIO_ARB_TIMEOUT_EN (WAIT-state timeout, reports a
// failed response with all-ones read data when it expires).
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   req_valid/wr/addr/din        per-requester request, held until req_done
//   req_done                     one-cycle completion pulse to the owner
//   rsp_dout, rsp_failed         response payload, valid with req_done, held
//   busy, grant_id               status: not idle / current-or-last owner
//   lcl_mmio_wr/rd/addr/din      strobes and payload to the shim
//   lcl_mmio_ack/rsp/dout/dv     completion from the shim
module mmio_axilite_arbiter #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ID_W           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_wr,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_din,
  output logic [N_REQ-1:0]      req_done,
  output logic [31:0]           rsp_dout,
  output logic                  rsp_failed,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic                  lcl_mmio_wr,
  output logic                  lcl_mmio_rd,
  output logic [31:0]           lcl_mmio_addr,
  output logic [31:0]           lcl_mmio_din,
  input  logic                  lcl_mmio_ack,
  input  logic                  lcl_mmio_rsp,
  input  logic [31:0]           lcl_mmio_dout,
  input  logic                  lcl_mmio_dv
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic                r_wr_type, w_wr_type_nxt;
  logic [ID_W-1:0]     w_grant_nxt;
  logic [31:0]         w_addr_nxt, w_din_nxt, w_dout_nxt;
  logic                w_failed_nxt, w_busy_nxt, w_mwr_nxt, w_mrd_nxt;
  logic [N_REQ-1:0]    w_done_nxt, w_grant_1hot;

  logic                w_any, w_found, w_pick_wr, w_cmpl, w_tout;
  logic [ID_W-1:0]     w_pick;
  logic [31:0]         w_pick_addr, w_pick_din;

  // Round-robin pick: lowest valid index >= r_ptr, else lowest valid overall.
  always_comb begin
    w_any       = |req_valid;
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_wr   = 1'b0;
    w_pick_addr = '0;
    w_pick_din  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (ID_W'(j) >= r_ptr)) begin
        w_found     = 1'b1;
        w_pick      = ID_W'(j);
        w_pick_wr   = req_wr[j];
        w_pick_addr = req_addr[j*32 +: 32];
        w_pick_din  = req_din[j*32 +: 32];
      end
    end
    if (!w_found) begin
      for (int j = N_REQ - 1; j >= 0; j--) begin
        if (req_valid[j]) begin
          w_pick      = ID_W'(j);
          w_pick_wr   = req_wr[j];
          w_pick_addr = req_addr[j*32 +: 32];
          w_pick_din  = req_din[j*32 +: 32];
        end
      end
    end
  end

  // One-hot of the owner, used for the req_done pulse.
  always_comb begin
    w_grant_1hot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_grant_1hot[j] = (grant_id == ID_W'(j));
    end
  end

  // Only the strobe matching the transaction type counts as completion.
  assign w_cmpl = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                  (r_wr_type ? lcl_mmio_ack : lcl_mmio_dv);

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tcnt;

  // Counts WAIT cycles; restarts for every issued transaction.
  always_ff @(posedge clk) begin
    if (!resetn || (r_state == S_ISSUE)) r_tcnt <= '0;
    else if (r_state == S_WAIT)         r_tcnt <= r_tcnt + CNT_W'(1);
  end

  assign w_tout = (r_state == S_WAIT) && (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam bit TOUT_EN = 1'b0;
  assign w_tout = TOUT_EN && (TIMEOUT_CYCLES != 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = w_cmpl ? S_DONE : S_WAIT;
      S_WAIT:  if (w_cmpl || w_tout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    w_grant_nxt   = grant_id;
    w_addr_nxt    = lcl_mmio_addr;
    w_din_nxt     = lcl_mmio_din;
    w_wr_type_nxt = r_wr_type;
    w_dout_nxt    = rsp_dout;
    w_failed_nxt  = rsp_failed;
    w_ptr_nxt     = r_ptr;
    w_done_nxt    = '0;
    w_mwr_nxt     = 1'b0;
    w_mrd_nxt     = 1'b0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt   = w_pick;
          w_addr_nxt    = w_pick_addr;
          w_din_nxt     = w_pick_din;
          w_wr_type_nxt = w_pick_wr;
          w_mwr_nxt     = w_pick_wr;
          w_mrd_nxt     = !w_pick_wr;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (w_cmpl) begin
          w_failed_nxt = lcl_mmio_rsp;
          w_dout_nxt   = r_wr_type ? 32'h0 : lcl_mmio_dout;
          w_done_nxt   = w_grant_1hot;
        end else if (w_tout) begin
          w_failed_nxt = 1'b1;
          w_dout_nxt   = 32'hFFFF_FFFF;
          w_done_nxt   = w_grant_1hot;
        end
      end
      S_DONE: begin
        w_ptr_nxt = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
      default: ;
    endcase
  end

  // Output / datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr         <= '0;
      r_wr_type     <= 1'b0;
      grant_id      <= '0;
      lcl_mmio_addr <= '0;
      lcl_mmio_din  <= '0;
      lcl_mmio_wr   <= 1'b0;
      lcl_mmio_rd   <= 1'b0;
      rsp_dout      <= '0;
      rsp_failed    <= 1'b0;
      req_done      <= '0;
      busy          <= 1'b0;
    end else begin
      r_ptr         <= w_ptr_nxt;
      r_wr_type     <= w_wr_type_nxt;
      grant_id      <= w_grant_nxt;
      lcl_mmio_addr <= w_addr_nxt;
      lcl_mmio_din  <= w_din_nxt;
      lcl_mmio_wr   <= w_mwr_nxt;
      lcl_mmio_rd   <= w_mrd_nxt;
      rsp_dout      <= w_dout_nxt;
      rsp_failed    <= w_failed_nxt;
      req_done      <= w_done_nxt;
      busy          <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_mmio_axilite_arbiter.sv
// Randomized bench for mmio_axilite_arbiter against a transaction-level model.
module tb_mmio_axilite_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned IW = 3;
`ifdef MMIO_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 16;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 1024;
  localparam bit          TO_EN = 1'b0;
`endif
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid, req_wr, req_done;
  logic [32*N-1:0] req_addr, req_din;
  logic [31:0]     rsp_dout, lcl_mmio_addr, lcl_mmio_din, lcl_mmio_dout;
  logic            rsp_failed, busy, lcl_mmio_wr, lcl_mmio_rd;
  logic            lcl_mmio_ack, lcl_mmio_rsp, lcl_mmio_dv;
  logic [IW-1:0]   grant_id;

  mmio_axilite_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .req_done(req_done), .rsp_dout(rsp_dout), .rsp_failed(rsp_failed),
    .busy(busy), .grant_id(grant_id),
    .lcl_mmio_wr(lcl_mmio_wr), .lcl_mmio_rd(lcl_mmio_rd),
    .lcl_mmio_addr(lcl_mmio_addr), .lcl_mmio_din(lcl_mmio_din),
    .lcl_mmio_ack(lcl_mmio_ack), .lcl_mmio_rsp(lcl_mmio_rsp),
    .lcl_mmio_dout(lcl_mmio_dout), .lcl_mmio_dv(lcl_mmio_dv)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // First requesting index at or after start, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < int'(N); k++) begin
      if (v[(start + k) % int'(N)]) return (start + k) % int'(N);
    end
    return -1;
  endfunction

  logic [N-1:0] v_valid, v_wr;
  logic [31:0]  v_addr[N], v_din[N];
  bit           pend[N];
  int           phase, owner, last_grant, rr_start, busy_cnt, resp_delay, n_done, n_rst;
  logic         m_wr, exp_failed, last_failed;
  logic [31:0]  m_addr, m_din, exp_dout, last_dout;
  bit           resp_drv, rst_drv, want_rst;
  int           rst_hold;

  always_comb begin
    req_valid = v_valid;
    req_wr    = v_wr;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[i*32 +: 32] = v_addr[i];
      req_din[i*32 +: 32]  = v_din[i];
    end
  end

  initial begin
    resetn = 1'b0; v_valid = '0; v_wr = '0;
    for (int i = 0; i < int'(N); i++) begin v_addr[i] = '0; v_din[i] = '0; pend[i] = 0; end
    lcl_mmio_ack = 0; lcl_mmio_dv = 0; lcl_mmio_rsp = 0; lcl_mmio_dout = '0;
    phase = P_IDLE; owner = 0; last_grant = 0; rr_start = 0; busy_cnt = 0; resp_delay = 0;
    m_wr = 0; m_addr = '0; m_din = '0; exp_dout = '0; exp_failed = 0;
    last_dout = '0; last_failed = 0; n_done = 0; n_rst = 0;
    resp_drv = 0; rst_drv = 1; want_rst = 0; rst_hold = 3;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;

      // Advance the model by the cycle that just ended.
      if (rst_drv) begin
        phase = P_IDLE; last_grant = 0; rr_start = 0;
        last_dout = '0; last_failed = 0; m_addr = '0; m_din = '0;
      end else begin
        case (phase)
          P_IDLE: begin
            owner = rr_pick(v_valid, rr_start);
            if (owner >= 0) begin
              phase = P_BUSY; busy_cnt = 0; last_grant = owner;
              m_wr = v_wr[owner]; m_addr = v_addr[owner]; m_din = v_din[owner];
              resp_delay = (TO_EN && $urandom_range(0, 5) == 0) ? 100000 : int'($urandom_range(0, 4));
            end
          end
          P_BUSY: begin
            if (resp_drv) begin
              phase = P_DONE; last_dout = exp_dout; last_failed = exp_failed;
            end else if (TO_EN && busy_cnt == int'(TO)) begin
              phase = P_DONE; last_dout = 32'hFFFF_FFFF; last_failed = 1'b1;
            end else busy_cnt++;
          end
          default: begin
            phase = P_IDLE; rr_start = (owner + 1) % int'(N);
          end
        endcase
      end

      // Compare DUT against the model.
      check("busy", 32'(busy), 32'(phase != P_IDLE));
      check("wr_strobe", 32'(lcl_mmio_wr), 32'(phase == P_BUSY && busy_cnt == 0 && m_wr));
      check("rd_strobe", 32'(lcl_mmio_rd), 32'(phase == P_BUSY && busy_cnt == 0 && !m_wr));
      check("grant_id", 32'(grant_id), 32'(last_grant));
      check("req_done", 32'(req_done), (phase == P_DONE) ? (32'd1 << owner) : 32'd0);
      check("rsp_dout", rsp_dout, last_dout);
      check("rsp_failed", 32'(rsp_failed), 32'(last_failed));
      if (phase != P_IDLE || rst_drv) begin
        check("mmio_addr", lcl_mmio_addr, m_addr);
        check("mmio_din", lcl_mmio_din, m_din);
      end
      if (phase == P_DONE) begin n_done++; pend[owner] = 0; v_valid[owner] = 1'b0; end

      // Drive the next cycle.
      if (cyc == 1200 || cyc == 2600) want_rst = 1;
      rst_drv = 0;
      if (rst_hold > 0) begin rst_hold--; rst_drv = 1; end
      else if (want_rst && phase == P_BUSY && busy_cnt >= 1) begin
        rst_drv = 1; want_rst = 0; n_rst++;
      end
      resetn = !rst_drv;

      for (int i = 0; i < int'(N); i++) begin
        if (phase == P_BUSY && i == owner) begin
          // Owner may scramble its payload or withdraw; neither affects the transfer.
          v_addr[i] = $urandom; v_din[i] = $urandom;
          if ($urandom_range(0, 7) == 0) v_valid[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1; v_valid[i] = 1'b1; v_wr[i] = 1'($urandom_range(0, 1));
          v_addr[i] = $urandom; v_din[i] = $urandom;
        end
      end
      if (rst_drv) begin
        v_valid = '0;
        for (int i = 0; i < int'(N); i++) pend[i] = 0;
      end

      resp_drv = 0; lcl_mmio_ack = 0; lcl_mmio_dv = 0;
      lcl_mmio_rsp = 1'($urandom_range(0, 1)); lcl_mmio_dout = $urandom;
      if (phase == P_BUSY && !rst_drv) begin
        if (busy_cnt == resp_delay) begin
          resp_drv = 1;
          if (m_wr) lcl_mmio_ack = 1'b1; else lcl_mmio_dv = 1'b1;
          exp_failed = lcl_mmio_rsp;
          exp_dout   = m_wr ? 32'h0 : lcl_mmio_dout;
        end else if (m_wr) lcl_mmio_dv = 1'($urandom_range(0, 1));
        else               lcl_mmio_ack = 1'($urandom_range(0, 1));
      end else begin
        // Stray or late completions outside a transaction must be ignored.
        lcl_mmio_ack = ($urandom_range(0, 3) == 0);
        lcl_mmio_dv  = ($urandom_range(0, 3) == 0);
      end
    end

    check("progress", 32'(n_done > 200), 32'd1);
    check("mid_resets", 32'(n_rst), 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
